pin_cmd_engine: RTL and testbench

Byte-stream command engine that sits directly upstream of the FPGA pin I/O stage. It decodes opcode/address/data bytes from a UART-style RX stream and maintains the registered drive image of all pins. It drives the pin stage's direction select and returns either a synchronised pin sample byte or an ack/nak on a TX stream. It is the only writer of the pin drive image and `write_enable`.

---
 rtl/pin_cmd_pkg.sv | 24 ++
 rtl/pin_sync.sv | 26 ++
 rtl/pin_cmd_engine.sv | 157 +++++++++++++++
 tb/tb_pin_cmd_engine.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_cmd_pkg.sv
// Shared opcodes, response codes, FSM state type and sizing helper for the
// pin command engine.
package pin_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'hA0;
  localparam logic [7:0] OP_READ  = 8'hA1;
  localparam logic [7:0] OP_MODE  = 8'hA2;

  localparam logic [7:0] RSP_ACK = 8'h55;
  localparam logic [7:0] RSP_NAK = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_ARG,
    ST_RESP
  } pin_cmd_state_t;

  function automatic int num_bytes(input int pins);
    return (pins + 7) / 8;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous levels.
module pin_sync #(
  parameter int WIDTH = 8
) (
  input  logic             CLK50,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pin_cmd_engine.sv
// Byte-stream command decoder owning the pin drive image and direction select;
// answers each complete command with one response byte.
module pin_cmd_engine
  import pin_cmd_pkg::*;
#(
  parameter int PINS_CONT      = 132,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                 CLK50,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [PINS_CONT-1:0] pin_sample,
  output logic [PINS_CONT-1:0] pin_drive,
  output logic                 write_enable
);

  localparam int NUM_BYTES = num_bytes(PINS_CONT);
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  pin_cmd_state_t       state_reg, state_next;
  logic [7:0]           op_reg, op_next;
  logic [7:0]           addr_reg, addr_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic                 write_enable_reg, write_enable_next;
  logic [CNT_W-1:0]     to_cnt_reg, to_cnt_next;
  logic [PINS_CONT-1:0] pin_drive_reg, pin_drive_next;

  logic [PINS_CONT-1:0] sync_q;
  logic [7:0]           sample_bytes [NUM_BYTES];
  logic [NUM_BYTES-1:0] byte_we;
  logic                 drive_we;
  logic                 rx_fire;
  logic                 busy;
  logic                 timeout_hit;

  pin_sync #(
    .WIDTH (PINS_CONT)
  ) u_pin_sync (
    .CLK50 (CLK50),
    .rst_n (rst_n),
    .d     (pin_sample),
    .q     (sync_q)
  );

  // The last bank byte may be partial: its missing pins read as 0 and its
  // extra write bits are simply dropped.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bank
      localparam int BW = ((PINS_CONT - gi * 8) >= 8) ? 8 : (PINS_CONT - gi * 8);
      assign sample_bytes[gi] = 8'(sync_q[gi*8 +: BW]);
      assign byte_we[gi] = drive_we && (addr_reg[IDX_W-1:0] == IDX_W'(gi));
      assign pin_drive_next[gi*8 +: BW] = byte_we[gi] ? rx_data[BW-1:0]
                                                      : pin_drive_reg[gi*8 +: BW];
    end
  endgenerate

  assign rx_ready     = (state_reg != ST_RESP);
  assign tx_valid     = (state_reg == ST_RESP);
  assign tx_data      = tx_data_reg;
  assign pin_drive    = pin_drive_reg;
  assign write_enable = write_enable_reg;

  assign rx_fire     = rx_valid && rx_ready;
  assign busy        = (state_reg == ST_GET_ADDR) || (state_reg == ST_GET_DATA) ||
                       (state_reg == ST_GET_ARG);
  assign timeout_hit = busy && !rx_fire && (to_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next        = state_reg;
    op_next           = op_reg;
    addr_next         = addr_reg;
    tx_data_next      = tx_data_reg;
    write_enable_next = write_enable_reg;
    drive_we          = 1'b0;
    to_cnt_next       = (rx_fire || !busy || timeout_hit) ? '0 : to_cnt_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (rx_fire) begin
          op_next = rx_data;
          case (rx_data)
            OP_WRITE, OP_READ: state_next = ST_GET_ADDR;
            OP_MODE:           state_next = ST_GET_ARG;
            default: begin
              tx_data_next = RSP_NAK;
              state_next   = ST_RESP;
            end
          endcase
        end
      end
      ST_GET_ADDR: begin
        if (rx_fire) begin
          addr_next = rx_data;
          if (op_reg == OP_WRITE) begin
            state_next = ST_GET_DATA;
          end else begin
            tx_data_next = (rx_data < 8'(NUM_BYTES)) ? sample_bytes[rx_data[IDX_W-1:0]]
                                                     : RSP_NAK;
            state_next   = ST_RESP;
          end
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_fire) begin
          // Out-of-range writes still swallow their data byte before the NAK.
          drive_we     = (addr_reg < 8'(NUM_BYTES));
          tx_data_next = (addr_reg < 8'(NUM_BYTES)) ? RSP_ACK : RSP_NAK;
          state_next   = ST_RESP;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_GET_ARG: begin
        if (rx_fire) begin
          write_enable_next = rx_data[0];
          tx_data_next      = RSP_ACK;
          state_next        = ST_RESP;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      op_reg           <= '0;
      addr_reg         <= '0;
      tx_data_reg      <= '0;
      write_enable_reg <= 1'b0;
      to_cnt_reg       <= '0;
      pin_drive_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      op_reg           <= op_next;
      addr_reg         <= addr_next;
      tx_data_reg      <= tx_data_next;
      write_enable_reg <= write_enable_next;
      to_cnt_reg       <= to_cnt_next;
      pin_drive_reg    <= pin_drive_next;
    end
  end

endmodule

// File: tb/tb_pin_cmd_engine.sv
// Self-checking bench for pin_cmd_engine: directed scenarios plus randomized
// commands scored against a byte-array model of the bank.
module tb_pin_cmd_engine;

  localparam int PINS = 132;
  localparam int NB   = 17;
  localparam int TMO  = 64;

  logic            CLK50 = 1'b0;
  logic            rst_n;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [PINS-1:0] pin_sample;
  logic [PINS-1:0] pin_drive;
  logic            write_enable;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_drive [NB];
  logic       m_we;

  pin_cmd_engine #(
    .PINS_CONT      (PINS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK50        (CLK50),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .pin_sample   (pin_sample),
    .pin_drive    (pin_drive),
    .write_enable (write_enable)
  );

  always #10 CLK50 = ~CLK50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int k = 0; k < NB; k++) m_drive[k] = 8'h00;
    m_we = 1'b0;
  endfunction

  function automatic logic [PINS-1:0] m_vec();
    logic [NB*8-1:0] t;
    for (int k = 0; k < NB; k++) t[k*8 +: 8] = m_drive[k];
    return t[PINS-1:0];
  endfunction

  function automatic logic [7:0] model_cmd(input logic [7:0] op, input logic [7:0] b1,
                                           input logic [7:0] b2);
    logic [NB*8-1:0] s;
    s = (NB*8)'(pin_sample);
    case (op)
      8'hA0: begin
        if (b1 < NB) begin
          m_drive[b1] = b2;
          return 8'h55;
        end
        return 8'hEE;
      end
      8'hA1: return (b1 < NB) ? s[b1*8 +: 8] : 8'hEE;
      8'hA2: begin
        m_we = b1[0];
        return 8'h55;
      end
      default: return 8'hEE;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_ready_at_byte got=%b want=1 byte=%h", rx_ready, b);
    end
    for (int i = 0; i < 16 && !done; i++) begin
      if (rx_ready === 1'b1) done = 1;
      @(posedge CLK50); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [7:0] d, output int lat);
    lat = -1;
    d   = 8'hxx;
    for (int i = 0; i < 16 && lat < 0; i++) begin
      if (tx_valid === 1'b1) begin
        d   = tx_data;
        lat = i;
      end
      @(posedge CLK50); #1;
    end
  endtask

  task automatic check_state(input string tag);
    checks++;
    if (pin_drive !== m_vec()) begin
      errors++;
      $display("FAIL %s pin_drive got=%h want=%h", tag, pin_drive, m_vec());
    end
    checks++;
    if (write_enable !== m_we) begin
      errors++;
      $display("FAIL %s write_enable got=%b want=%b", tag, write_enable, m_we);
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                         input string tag);
    logic [7:0] exp_rsp, got;
    int         lat;
    exp_rsp = model_cmd(op, b1, b2);
    send_byte(op);
    if (op == 8'hA0 || op == 8'hA1 || op == 8'hA2) send_byte(b1);
    if (op == 8'hA0) send_byte(b2);
    wait_resp(got, lat);
    checks++;
    if (got !== exp_rsp) begin
      errors++;
      $display("FAIL %s response got=%h want=%h", tag, got, exp_rsp);
    end
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL %s response_latency got=%0d want=0", tag, lat);
    end
    check_state(tag);
    $display("%s: op=%h b1=%h b2=%h rsp=%h exp=%h", tag, op, b1, b2, got, exp_rsp);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (pin_drive !== '0 || write_enable !== 1'b0 || tx_valid !== 1'b0 ||
        tx_data !== 8'h00 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s reset_outputs got drive=%h we=%b txv=%b txd=%h rxr=%b want 0/0/0/00/1",
               tag, pin_drive, write_enable, tx_valid, tx_data, rx_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b1;
    pin_sample = '0;
    model_clear();
    #25;
    check_reset_outputs("reset");
    @(negedge CLK50) rst_n = 1'b1;
    @(posedge CLK50); #1;
    check_reset_outputs("reset_released");
    $display("reset: done");
  endtask

  task automatic test_directed();
    run_cmd(8'hA0, 8'h03, 8'h5A, "write_b3");
    checks++;
    if (pin_drive !== (PINS'(8'h5A) << 24)) begin
      errors++;
      $display("FAIL write_b3 image got=%h want=5a<<24", pin_drive);
    end
    run_cmd(8'hA0, 8'h10, 8'hFF, "write_top");
    checks++;
    if (pin_drive[131:128] !== 4'hF) begin
      errors++;
      $display("FAIL write_top top_nibble got=%h want=f", pin_drive[131:128]);
    end
    pin_sample[131:128] = 4'hF;
    repeat (2) @(posedge CLK50);
    #1;
    run_cmd(8'hA1, 8'h10, 8'h00, "read_top");
    run_cmd(8'hA2, 8'h01, 8'h00, "mode_drive");
    run_cmd(8'hA1, 8'h11, 8'h00, "read_oor");
    run_cmd(8'hA0, 8'h11, 8'h42, "write_oor");
    run_cmd(8'h7C, 8'h00, 8'h00, "bad_opcode");
    run_cmd(8'hA2, 8'h00, 8'h00, "mode_sample");
  endtask

  task automatic test_timeout();
    logic [7:0] got, exp_rsp;
    int         lat;
    bit         spurious;
    // Data byte lands on the very edge the timeout would fire: accept wins.
    send_byte(8'hA0);
    send_byte(8'h02);
    repeat (TMO - 1) @(posedge CLK50);
    #1;
    exp_rsp = model_cmd(8'hA0, 8'h02, 8'h11);
    send_byte(8'h11);
    wait_resp(got, lat);
    checks++;
    if (got !== exp_rsp || lat !== 0) begin
      errors++;
      $display("FAIL timeout_edge_accept got=%h lat=%0d want=%h lat=0", got, lat, exp_rsp);
    end
    check_state("timeout_edge_accept");
    $display("timeout_edge_accept: rsp=%h exp=%h", got, exp_rsp);

    send_byte(8'hA0);
    send_byte(8'h02);
    spurious = 0;
    for (int i = 0; i < TMO; i++) begin
      if (tx_valid !== 1'b0) spurious = 1;
      @(posedge CLK50); #1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL timeout_silent tx_valid got=1 want=0");
    end
    check_state("timeout_expired");
    $display("timeout_expired: abandoned A0 02");
    run_cmd(8'hA0, 8'h02, 8'h33, "after_timeout");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_rsp, got;
    logic [7:0] mode;
    int         lat;
    tx_ready = 1'b0;
    pin_sample = PINS'({$urandom, $urandom, $urandom, $urandom, $urandom});
    repeat (2) @(posedge CLK50);
    #1;
    exp_rsp = model_cmd(8'hA1, 8'h00, 8'h00);
    send_byte(8'hA1);
    send_byte(8'h00);
    rx_data  = 8'hA2;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_rsp || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d got txv=%b txd=%h rxr=%b want 1/%h/0",
                 i, tx_valid, tx_data, rx_ready, exp_rsp);
      end
      @(posedge CLK50); #1;
    end
    tx_ready = 1'b1;
    @(posedge CLK50); #1;
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got txv=%b rxr=%b want 0/1", tx_valid, rx_ready);
    end
    @(posedge CLK50); #1;
    rx_valid = 1'b0;
    mode = 8'($urandom_range(0, 1));
    exp_rsp = model_cmd(8'hA2, mode, 8'h00);
    send_byte(mode);
    wait_resp(got, lat);
    checks++;
    if (got !== exp_rsp || lat !== 0) begin
      errors++;
      $display("FAIL backpressure_next_cmd got=%h lat=%0d want=%h lat=0", got, lat, exp_rsp);
    end
    check_state("backpressure_next_cmd");
    $display("backpressure: held byte A2 then mode=%h rsp=%h exp=%h", mode, got, exp_rsp);
  endtask

  task automatic test_reset_mid();
    run_cmd(8'hA0, 8'h05, 8'hC3, "pre_reset_write");
    run_cmd(8'hA2, 8'h01, 8'h00, "pre_reset_mode");
    send_byte(8'hA0);
    send_byte(8'h05);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_mid_cmd");
    model_clear();
    @(negedge CLK50) rst_n = 1'b1;
    @(posedge CLK50); #1;
    $display("reset_mid_cmd: partial A0 05 dropped");
    run_cmd(8'hA0, 8'h05, 8'h77, "after_reset");
  endtask

  task automatic test_random();
    logic [159:0] rnd;
    logic [7:0]   op, b1, b2;
    int           r;
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      b1 = ($urandom_range(0, 99) < 90) ? 8'($urandom_range(0, NB - 1))
                                        : 8'($urandom_range(NB, 255));
      b2 = 8'($urandom);
      if (r <= 3) begin
        op = 8'hA0;
      end else if (r <= 6) begin
        op = 8'hA1;
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        pin_sample = rnd[PINS-1:0];
        // Minimum settle: address byte lands two edges after the change.
        @(posedge CLK50); #1;
      end else if (r <= 8) begin
        op = 8'hA2;
        b1 = 8'($urandom);
      end else begin
        op = 8'($urandom);
        while (op == 8'hA0 || op == 8'hA1 || op == 8'hA2) op = 8'($urandom);
      end
      run_cmd(op, b1, b2, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
